// File: rtl/axil_decoupler_if.sv
// AXI4-Lite bundle used on both sides of axil_decoupler.
interface axil_intfc #(
   parameter bit          IS_64_BIT      = 1'b0,
   parameter int unsigned AXI_ADDR_WIDTH = 32
);
   localparam int unsigned DataW = IS_64_BIT ? 64 : 32;

   logic                      awvalid;
   logic                      awready;
   logic [AXI_ADDR_WIDTH-1:0] awaddr;
   logic                      wvalid;
   logic                      wready;
   logic [DataW-1:0]          wdata;
   logic [DataW/8-1:0]        wstrb;
   logic                      bvalid;
   logic                      bready;
   logic [1:0]                bresp;
   logic                      arvalid;
   logic                      arready;
   logic [AXI_ADDR_WIDTH-1:0] araddr;
   logic                      rvalid;
   logic                      rready;
   logic [DataW-1:0]          rdata;
   logic [1:0]                rresp;

   modport master (
      output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport slave (
      input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/axil_decoupler.sv
// AXI4-Lite decoupler: gates new requests, drains in-flight ones, then reports isolation.
// Define AXIL_DECOUPLE_RESP_EN to answer upstream requests locally (SLVERR) while decoupled.
module axil_decoupler #(
   parameter bit          IS_64_BIT       = 1'b0,
   parameter int unsigned AXI_ADDR_WIDTH  = 32,
   parameter int unsigned MAX_OUTSTANDING = 8
) (
   input  logic      aclk,
   input  logic      areset,
   axil_intfc.slave  s_axil,
   axil_intfc.master m_axil,
   input  logic      decouple,
   output logic      decouple_done
);
   localparam int unsigned     DataW  = IS_64_BIT ? 64 : 32;
   localparam int unsigned     CntW   = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(MAX_OUTSTANDING);

   typedef enum logic [1:0] {StNormal, StDraining, StDecoupled} state_e;

   state_e          state_q, state_d;
   logic            decouple_q, done_q;
   logic [CntW-1:0] aw_cnt_q, w_cnt_q, ar_cnt_q;
   logic            pend_aw_q, pend_w_q, pend_ar_q;
   logic            gate_aw, gate_w, gate_ar;
   logic            aw_hs, w_hs, ar_hs, b_hs, r_hs;
   logic            all_idle, local_idle;

   function automatic logic [CntW-1:0] cnt_next(input logic [CntW-1:0] cnt, input logic inc,
                                                input logic dec);
      if (inc && !dec) return cnt + CntW'(1);
      // A response with nothing outstanding is a downstream error; hold at zero.
      if (dec && !inc && cnt != '0) return cnt - CntW'(1);
      return cnt;
   endfunction

   assign m_axil.awaddr = s_axil.awaddr[AXI_ADDR_WIDTH-1:0];
   assign m_axil.araddr = s_axil.araddr[AXI_ADDR_WIDTH-1:0];
   assign m_axil.wdata  = s_axil.wdata[DataW-1:0];
   assign m_axil.wstrb  = s_axil.wstrb[DataW/8-1:0];

   assign m_axil.awvalid = s_axil.awvalid & gate_aw;
   assign m_axil.wvalid  = s_axil.wvalid & gate_w;
   assign m_axil.arvalid = s_axil.arvalid & gate_ar;

   assign aw_hs = m_axil.awvalid & m_axil.awready;
   assign w_hs  = m_axil.wvalid & m_axil.wready;
   assign ar_hs = m_axil.arvalid & m_axil.arready;
   assign b_hs  = m_axil.bvalid & m_axil.bready;
   assign r_hs  = m_axil.rvalid & m_axil.rready;

   assign all_idle = (aw_cnt_q == '0) && (w_cnt_q == '0) && (ar_cnt_q == '0) &&
                     !pend_aw_q && !pend_w_q && !pend_ar_q;

   // Gates depend only on registered state so they never combinationally follow valid.
   always_comb begin
      gate_aw = 1'b0;
      gate_w  = 1'b0;
      gate_ar = 1'b0;
      case (state_q)
         StNormal: begin
            gate_aw = 1'b1;
            gate_w  = 1'b1;
            gate_ar = 1'b1;
         end
         StDraining: begin
            gate_aw = w_cnt_q > aw_cnt_q;
            gate_w  = aw_cnt_q > w_cnt_q;
         end
         default: ;
      endcase
      if (aw_cnt_q == CntMax) gate_aw = 1'b0;
      if (w_cnt_q == CntMax)  gate_w  = 1'b0;
      if (ar_cnt_q == CntMax) gate_ar = 1'b0;
      if (pend_aw_q) gate_aw = 1'b1;
      if (pend_w_q)  gate_w  = 1'b1;
      if (pend_ar_q) gate_ar = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StNormal:    if (decouple_q) state_d = StDraining;
         StDraining: begin
            if (!decouple_q)   state_d = StNormal;
            else if (all_idle) state_d = StDecoupled;
         end
         StDecoupled: if (!decouple_q && local_idle) state_d = StNormal;
         default:     state_d = StNormal;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q    <= StNormal;
         decouple_q <= 1'b0;
         done_q     <= 1'b0;
         aw_cnt_q   <= '0;
         w_cnt_q    <= '0;
         ar_cnt_q   <= '0;
         pend_aw_q  <= 1'b0;
         pend_w_q   <= 1'b0;
         pend_ar_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         decouple_q <= decouple;
         done_q     <= (state_d == StDecoupled);
         aw_cnt_q   <= cnt_next(aw_cnt_q, aw_hs, b_hs);
         w_cnt_q    <= cnt_next(w_cnt_q, w_hs, b_hs);
         ar_cnt_q   <= cnt_next(ar_cnt_q, ar_hs, r_hs);
         pend_aw_q  <= pend_aw_q ? !aw_hs : (m_axil.awvalid & !m_axil.awready);
         pend_w_q   <= pend_w_q ? !w_hs : (m_axil.wvalid & !m_axil.wready);
         pend_ar_q  <= pend_ar_q ? !ar_hs : (m_axil.arvalid & !m_axil.arready);
      end
   end

   assign decouple_done = done_q;

`ifdef AXIL_DECOUPLE_RESP_EN
   typedef enum logic {WIdle, WResp} wstate_e;
   typedef enum logic {RIdle, RResp} rstate_e;

   wstate_e wr_st_q, wr_st_d;
   rstate_e rd_st_q, rd_st_d;
   logic    aw_got_q, aw_got_d, w_got_q, w_got_d;
   logic    loc_aw_ready, loc_w_ready, loc_ar_ready;
   logic    in_dec;

   assign in_dec = (state_q == StDecoupled);

   // New work is taken only while isolation is still requested; a half-accepted write
   // is always allowed to finish so the exit condition can be reached.
   always_comb begin
      loc_aw_ready = in_dec && (wr_st_q == WIdle) && !aw_got_q && (decouple_q || w_got_q);
      loc_w_ready  = in_dec && (wr_st_q == WIdle) && !w_got_q && (decouple_q || aw_got_q);
      loc_ar_ready = in_dec && (rd_st_q == RIdle) && decouple_q;
      aw_got_d     = aw_got_q | (s_axil.awvalid & loc_aw_ready);
      w_got_d      = w_got_q | (s_axil.wvalid & loc_w_ready);
      wr_st_d      = wr_st_q;
      rd_st_d      = rd_st_q;
      if (wr_st_q == WIdle && aw_got_d && w_got_d) begin
         wr_st_d  = WResp;
         aw_got_d = 1'b0;
         w_got_d  = 1'b0;
      end else if (wr_st_q == WResp && s_axil.bready) begin
         wr_st_d = WIdle;
      end
      if (rd_st_q == RIdle && s_axil.arvalid && loc_ar_ready) rd_st_d = RResp;
      else if (rd_st_q == RResp && s_axil.rready)             rd_st_d = RIdle;
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         wr_st_q  <= WIdle;
         rd_st_q  <= RIdle;
         aw_got_q <= 1'b0;
         w_got_q  <= 1'b0;
      end else begin
         wr_st_q  <= wr_st_d;
         rd_st_q  <= rd_st_d;
         aw_got_q <= aw_got_d;
         w_got_q  <= w_got_d;
      end
   end

   assign local_idle = (wr_st_q == WIdle) && !aw_got_q && !w_got_q && (rd_st_q == RIdle);

   assign s_axil.awready = (m_axil.awready & gate_aw) | loc_aw_ready;
   assign s_axil.wready  = (m_axil.wready & gate_w) | loc_w_ready;
   assign s_axil.arready = (m_axil.arready & gate_ar) | loc_ar_ready;

   assign s_axil.bvalid = (wr_st_q == WResp) ? 1'b1 : m_axil.bvalid;
   assign s_axil.bresp  = (wr_st_q == WResp) ? 2'b10 : m_axil.bresp;
   assign m_axil.bready = s_axil.bready & (wr_st_q != WResp);
   assign s_axil.rvalid = (rd_st_q == RResp) ? 1'b1 : m_axil.rvalid;
   assign s_axil.rresp  = (rd_st_q == RResp) ? 2'b10 : m_axil.rresp;
   assign s_axil.rdata  = (rd_st_q == RResp) ? '0 : m_axil.rdata;
   assign m_axil.rready = s_axil.rready & (rd_st_q != RResp);
`else
   assign local_idle = 1'b1;

   assign s_axil.awready = m_axil.awready & gate_aw;
   assign s_axil.wready  = m_axil.wready & gate_w;
   assign s_axil.arready = m_axil.arready & gate_ar;

   assign s_axil.bvalid = m_axil.bvalid;
   assign s_axil.bresp  = m_axil.bresp;
   assign m_axil.bready = s_axil.bready;
   assign s_axil.rvalid = m_axil.rvalid;
   assign s_axil.rresp  = m_axil.rresp;
   assign s_axil.rdata  = m_axil.rdata;
   assign m_axil.rready = s_axil.rready;
`endif
endmodule

// File: tb/tb_axil_decoupler.sv
// Directed bench for axil_decoupler (cap of 2 outstanding per counter).
module tb_axil_decoupler;
   logic clk = 1'b0;
   logic rst;
   logic decouple;
   logic decouple_done;
   int   total = 0;
   int   bad   = 0;

   axil_intfc #(.IS_64_BIT(1'b0), .AXI_ADDR_WIDTH(32)) s_if ();
   axil_intfc #(.IS_64_BIT(1'b0), .AXI_ADDR_WIDTH(32)) m_if ();

   axil_decoupler #(
      .IS_64_BIT      (1'b0),
      .AXI_ADDR_WIDTH (32),
      .MAX_OUTSTANDING(2)
   ) dut (
      .aclk         (clk),
      .areset       (rst),
      .s_axil       (s_if),
      .m_axil       (m_if),
      .decouple     (decouple),
      .decouple_done(decouple_done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      decouple = 1'b0;
      s_if.awvalid = 1'b0; s_if.awaddr = '0; s_if.wvalid = 1'b0; s_if.wdata = '0;
      s_if.wstrb = '0; s_if.bready = 1'b0; s_if.arvalid = 1'b0; s_if.araddr = '0;
      s_if.rready = 1'b0;
      m_if.awready = 1'b0; m_if.wready = 1'b0; m_if.bvalid = 1'b0; m_if.bresp = 2'b00;
      m_if.arready = 1'b0; m_if.rvalid = 1'b0; m_if.rdata = '0; m_if.rresp = 2'b00;
      tick(); tick(); tick();
      rst = 1'b0;
      tick();
      chk("reset_done", decouple_done, 0);
      chk("reset_awvalid", m_if.awvalid, 0);

      // Pass-through write then read, checked in the same cycle as the request.
      s_if.awvalid = 1; s_if.awaddr = 32'h10; s_if.wvalid = 1; s_if.wdata = 32'hDEADBEEF;
      s_if.wstrb = 4'hF; m_if.awready = 1; m_if.wready = 1;
      #1;
      chk("pt_awvalid", m_if.awvalid, 1);
      chk("pt_awaddr", m_if.awaddr, 32'h10);
      chk("pt_wdata", m_if.wdata, 32'hDEADBEEF);
      chk("pt_wstrb", m_if.wstrb, 4'hF);
      chk("pt_awready", s_if.awready, 1);
      chk("pt_wready", s_if.wready, 1);
      tick();
      s_if.awvalid = 0; s_if.wvalid = 0;
      m_if.bvalid = 1; m_if.bresp = 2'b00; s_if.bready = 1;
      #1;
      chk("pt_bvalid", s_if.bvalid, 1);
      chk("pt_bresp", s_if.bresp, 2'b00);
      chk("pt_bready", m_if.bready, 1);
      tick();
      m_if.bvalid = 0;
      s_if.arvalid = 1; s_if.araddr = 32'h10; m_if.arready = 1;
      #1;
      chk("pt_arvalid", m_if.arvalid, 1);
      chk("pt_araddr", m_if.araddr, 32'h10);
      chk("pt_arready", s_if.arready, 1);
      tick();
      s_if.arvalid = 0;
      m_if.rvalid = 1; m_if.rdata = 32'hDEADBEEF; m_if.rresp = 2'b00; s_if.rready = 1;
      #1;
      chk("pt_rvalid", s_if.rvalid, 1);
      chk("pt_rdata", s_if.rdata, 32'hDEADBEEF);
      chk("pt_rresp", s_if.rresp, 2'b00);
      tick();
      m_if.rvalid = 0;

      // Cap: two writes outstanding with B withheld block the third AW.
      s_if.awvalid = 1; s_if.wvalid = 1; s_if.awaddr = 32'h20;
      tick(); tick();
      s_if.wvalid = 0;
      #1;
      chk("cap_awready", s_if.awready, 0);
      chk("cap_awvalid", m_if.awvalid, 0);
      tick();
      chk("cap_awready_hold", s_if.awready, 0);
      m_if.bvalid = 1;
      #1;
      chk("cap_same_cycle", s_if.awready, 0);
      tick();
      m_if.bvalid = 0;
      #1;
      chk("cap_reopen_ready", s_if.awready, 1);
      chk("cap_reopen_valid", m_if.awvalid, 1);
      tick();
      s_if.awvalid = 0; s_if.wvalid = 1;
      tick();
      s_if.wvalid = 0; m_if.bvalid = 1;
      tick(); tick();
      m_if.bvalid = 0;

      // Drain: two reads outstanding, then decouple; new AR must be held off.
      s_if.arvalid = 1; m_if.arready = 1;
      tick(); tick();
      s_if.arvalid = 0;
      decouple = 1;
      tick(); tick();
      m_if.rvalid = 1;
      tick();
      m_if.rvalid = 0;
      s_if.arvalid = 1; s_if.araddr = 32'h30;
      #1;
      chk("drain_ar_blocked", m_if.arvalid, 0);
      chk("drain_arready", s_if.arready, 0);
      chk("drain_done_low", decouple_done, 0);
      tick(); tick(); tick();
      chk("drain_ar_blocked2", m_if.arvalid, 0);
      s_if.arvalid = 0;
      m_if.rvalid = 1;
      tick();
      m_if.rvalid = 0;
      chk("drain_done_wait", decouple_done, 0);
      tick();
      chk("drain_done_high", decouple_done, 1);
      decouple = 0;
      tick();
      chk("release_done_hold", decouple_done, 1);
      tick();
      chk("release_done_low", decouple_done, 0);

      // Orphan W: AW accepted before decouple, W arrives during draining.
      s_if.awvalid = 1; m_if.awready = 1; s_if.awaddr = 32'h40;
      tick();
      s_if.awvalid = 0; decouple = 1;
      tick(); tick();
      s_if.wvalid = 1; m_if.wready = 1;
      #1;
      chk("orphan_wvalid", m_if.wvalid, 1);
      chk("orphan_wready", s_if.wready, 1);
      tick();
      s_if.wvalid = 0; m_if.bvalid = 1;
      tick();
      m_if.bvalid = 0;
      chk("orphan_done_wait", decouple_done, 0);
      tick();
      chk("orphan_done_high", decouple_done, 1);
      decouple = 0;
      tick(); tick();

      // Stalled valid: AW presented with awready low must survive the decouple request.
      m_if.awready = 0; s_if.awvalid = 1; s_if.awaddr = 32'h50;
      #1;
      chk("stall_valid0", m_if.awvalid, 1);
      decouple = 1;
      tick(); tick();
      chk("stall_valid1", m_if.awvalid, 1);
      tick();
      chk("stall_valid2", m_if.awvalid, 1);
      chk("stall_done_low", decouple_done, 0);
      m_if.awready = 1;
      #1;
      chk("stall_awready", s_if.awready, 1);
      tick();
      s_if.awvalid = 0; s_if.wvalid = 1; m_if.wready = 1;
      tick();
      s_if.wvalid = 0; m_if.bvalid = 1;
      tick();
      m_if.bvalid = 0;
      tick();
      chk("stall_done_high", decouple_done, 1);

`ifdef AXIL_DECOUPLE_RESP_EN
      // Local SLVERR responses while decoupled; downstream stays quiet.
      s_if.awvalid = 1; s_if.wvalid = 1; s_if.bready = 0;
      #1;
      chk("loc_awready", s_if.awready, 1);
      chk("loc_wready", s_if.wready, 1);
      chk("loc_m_awvalid", m_if.awvalid, 0);
      chk("loc_m_wvalid", m_if.wvalid, 0);
      tick();
      s_if.awvalid = 0; s_if.wvalid = 0;
      chk("loc_bvalid", s_if.bvalid, 1);
      chk("loc_bresp", s_if.bresp, 2'b10);
      tick();
      chk("loc_bvalid_hold", s_if.bvalid, 1);
      s_if.bready = 1;
      tick();
      chk("loc_bvalid_clr", s_if.bvalid, 0);
      s_if.arvalid = 1; s_if.rready = 0;
      #1;
      chk("loc_arready", s_if.arready, 1);
      chk("loc_m_arvalid", m_if.arvalid, 0);
      tick();
      s_if.arvalid = 0;
      chk("loc_rvalid", s_if.rvalid, 1);
      chk("loc_rresp", s_if.rresp, 2'b10);
      chk("loc_rdata", s_if.rdata, 0);
      s_if.rready = 1;
      tick();
      chk("loc_rvalid_clr", s_if.rvalid, 0);
      decouple = 0;
      tick(); tick();
      chk("loc_exit_done", decouple_done, 0);
      s_if.arvalid = 1; m_if.arready = 1;
      #1;
      chk("loc_exit_arvalid", m_if.arvalid, 1);
      tick();
      s_if.arvalid = 0; m_if.rvalid = 1;
      tick();
      m_if.rvalid = 0;
`else
      // Without local responder, upstream requests stall until decouple is released.
      s_if.awvalid = 1; s_if.awaddr = 32'h60; m_if.awready = 1;
      #1;
      chk("dec_awready", s_if.awready, 0);
      chk("dec_m_awvalid", m_if.awvalid, 0);
      tick(); tick(); tick();
      chk("dec_awready2", s_if.awready, 0);
      decouple = 0;
      tick(); tick();
      chk("dec_exit_done", decouple_done, 0);
      chk("dec_exit_awvalid", m_if.awvalid, 1);
      chk("dec_exit_awready", s_if.awready, 1);
      tick();
      s_if.awvalid = 0; s_if.wvalid = 1;
      tick();
      s_if.wvalid = 0; m_if.bvalid = 1;
      tick();
      m_if.bvalid = 0;
`endif
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
